jstk2_spi_responder: RTL and testbench

- SPI mode-0 slave that emulates the PmodJSTK2 joystick module, i.e. the peripheral end of the existing joystick SPI link.
- Takes 10-bit X/Y values and button states from fabric and serves them on MISO as the standard 5-byte JSTK2 packet whenever a master frames a transfer with SS/SCLK.
- Used as the loopback target for the joystick interface in simulation, and on a second board to stand in for the physical Pmod.

---
 rtl/jstk2_pkg.sv | 35 +++
 rtl/jstk2_spi_responder_if.sv | 12 +
 rtl/spi_sync_edge.sv | 39 +++
 rtl/jstk2_spi_responder.sv | 168 ++++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/jstk2_pkg.sv
// Shared definitions for the PmodJSTK2 SPI responder: packet layout, command codes and FSM states.
// Ports: none (package).
// Packet bytes go on the wire in declaration order (x_lo first), each byte MSB first.
package jstk2_pkg;

  localparam int         JSTK2_PKT_BYTES   = 5;
  localparam logic [7:0] JSTK2_CMD_SET_LED = 8'h84;

  typedef struct packed {
    logic [7:0] x_lo;
    logic [7:0] x_hi;
    logic [7:0] y_lo;
    logic [7:0] y_hi;
    logic [7:0] btn;
  } jstk2_pkt_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } jstk2_state_t;

  // Builds the 5-byte report from raw fabric values.
  function automatic jstk2_pkt_t jstk2_build_pkt(input logic [9:0] x,
                                                 input logic [9:0] y,
                                                 input logic [1:0] b);
    jstk2_pkt_t p;
    p.x_lo = x[7:0];
    p.x_hi = {6'b0, x[9:8]};
    p.y_lo = y[7:0];
    p.y_hi = {6'b0, y[9:8]};
    p.btn  = {6'b0, b};
    return p;
  endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// SPI pin bundle between a joystick master and the JSTK2 responder.
// Ports: SS (active-low select), SCLK (mode 0, idle low), MOSI, MISO.
// master drives SS/SCLK/MOSI and reads MISO; slave is the mirror image.
interface jstk2_spi_responder_if;
  logic SS;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS, output SCLK, output MOSI, input MISO);
  modport slave  (input SS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer for one asynchronous SPI pin plus single-cycle rise/fall pulses.
// Ports: clk, rst (sync, active-high), din (async pin), dout (synced level), rise/fall (pulses).
// Edge pulses appear STAGES cycles after the pin changes; the consumer acts one cycle later.
module spi_sync_edge #(
  parameter int STAGES    = 2,    // must be at least 2
  parameter bit RESET_VAL = 1'b0  // idle level of the pin
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  // Edges are suppressed until the chain has been refilled from the real pin
  // after reset; otherwise a pin held away from RESET_VAL across reset would
  // look like a fresh edge (e.g. SS still low after a mid-frame reset).
  logic [STAGES:0]   prime;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      prime <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      prime <= {prime[STAGES-1:0], 1'b1};
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = prime[STAGES] &  dout & ~prev;
  assign fall = prime[STAGES] & ~dout &  prev;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave emulating a PmodJSTK2: serves a snapshot of x_val/y_val/btn as the 5-byte packet.
// Ports: clk, rst (sync, active-high), spi (SS/SCLK/MOSI/MISO), x_val, y_val, btn, frame_done, busy;
//        with JSTK2_LED_CMD_EN defined also led_r/led_g/led_b/led_valid from the 0x84 set-LED command.
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PACKET_BYTES = JSTK2_PKT_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  jstk2_spi_responder_if.slave   spi,
  input  logic [9:0]             x_val,
  input  logic [9:0]             y_val,
  input  logic [1:0]             btn,
  output logic                   frame_done,
  output logic                   busy
`ifdef JSTK2_LED_CMD_EN
  ,
  output logic [7:0]             led_r,
  output logic [7:0]             led_g,
  output logic [7:0]             led_b,
  output logic                   led_valid
`endif
);

  localparam int PKT_W     = $bits(jstk2_pkt_t);
  localparam int DONE_BITS = PACKET_BYTES * 8;
  // Shift register is at least one full report wide; bytes past PACKET_BYTES are masked to 0.
  localparam int SH_W      = ((PACKET_BYTES > JSTK2_PKT_BYTES) ? PACKET_BYTES : JSTK2_PKT_BYTES) * 8;
  localparam logic [SH_W-1:0] KEEP_MASK = ~({SH_W{1'b1}} >> DONE_BITS);

  // ---------------- pin synchronizers ----------------
  logic ss_lvl_unused, ss_rise, ss_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(spi.SS),
    .dout(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi.SCLK),
    .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi.MOSI),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // ---------------- FSM ----------------
  jstk2_state_t state_q, state_d;
  logic [SH_W-1:0] shreg;
  logic [5:0]      bit_cnt;
  logic            miso_q;
  logic [SH_W-1:0] load_val;

  assign load_val = (SH_W'(jstk2_build_pkt(x_val, y_val, btn)) << (SH_W - PKT_W)) & KEEP_MASK;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = SHIFT;
      SHIFT:   if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == SHIFT);
    frame_done = (state_q == SHIFT) && ss_rise && (32'(bit_cnt) >= DONE_BITS);
  end

  // ---------------- shift datapath ----------------
  // In IDLE only SS falling matters, so a coincident SCLK edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            shreg   <= load_val;
            bit_cnt <= '0;
            miso_q  <= load_val[SH_W-1];
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            miso_q <= 1'b0;
          end else begin
            if (sclk_rise && (bit_cnt != 6'h3F)) bit_cnt <= bit_cnt + 6'd1;
            if (sclk_fall) begin
              // Zero refill: clocks past the packet read 0 instead of wrapping.
              shreg  <= {shreg[SH_W-2:0], 1'b0};
              miso_q <= shreg[SH_W-2];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign spi.MISO = miso_q;

`ifdef JSTK2_LED_CMD_EN
  // ---------------- set-LED command decode ----------------
  logic [7:0] rx_byte, cmd_q, r_q, g_q;
  logic [7:0] rx_next;
  logic       led_vld_q;

  assign rx_next = {rx_byte[6:0], mosi_s};

  // bit_cnt still holds the pre-increment count here, so 7 marks the 8th bit of a byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte   <= '0;
      cmd_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      led_r     <= '0;
      led_g     <= '0;
      led_b     <= '0;
      led_vld_q <= 1'b0;
    end else begin
      led_vld_q <= 1'b0;
      if ((state_q == IDLE) && ss_fall) begin
        rx_byte <= '0;
        cmd_q   <= '0;
      end else if ((state_q == SHIFT) && !ss_rise && sclk_rise) begin
        rx_byte <= rx_next;
        if (bit_cnt[2:0] == 3'd7) begin
          case (bit_cnt[5:3])
            3'd0: cmd_q <= rx_next;
            3'd1: r_q   <= rx_next;
            3'd2: g_q   <= rx_next;
            3'd3: begin
              if (cmd_q == JSTK2_CMD_SET_LED) begin
                led_r     <= r_q;
                led_g     <= g_q;
                led_b     <= rx_next;
                led_vld_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign led_valid = led_vld_q;
`else
  logic mosi_unused;
  assign mosi_unused = mosi_s;
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Directed bench for jstk2_spi_responder: frames driven at clk/16 SCLK, MISO bytes checked against hand values.
// Ports: none (top-level bench); instantiates jstk2_spi_responder_if as the SPI master side.
// Optional LED-command scenario runs only when JSTK2_LED_CMD_EN is defined.
module tb_jstk2_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_val, y_val;
  logic [1:0] btn;
  logic       frame_done, busy;
`ifdef JSTK2_LED_CMD_EN
  logic [7:0] led_r, led_g, led_b;
  logic       led_valid;
  int         lv_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [63:0] rx;
  logic        busy_mid;

  always #5 clk = ~clk;

  jstk2_spi_responder_if spi_if ();

  jstk2_spi_responder dut (
    .clk(clk),
    .rst(rst),
    .spi(spi_if),
    .x_val(x_val),
    .y_val(y_val),
    .btn(btn),
    .frame_done(frame_done),
    .busy(busy)
`ifdef JSTK2_LED_CMD_EN
    ,
    .led_r(led_r),
    .led_g(led_g),
    .led_b(led_b),
    .led_valid(led_valid)
`endif
  );

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
`ifdef JSTK2_LED_CMD_EN
    if (led_valid) lv_cnt++;
`endif
  end

  // One SCLK period: MOSI changes while SCLK is low, MISO sampled at the rising edge.
  task automatic sclk_cycle(input logic mosi_b, output logic miso_b);
    spi_if.MOSI = mosi_b;
    repeat (8) @(negedge clk);
    spi_if.SCLK = 1'b1;
    miso_b = spi_if.MISO;
    repeat (8) @(negedge clk);
    spi_if.SCLK = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input logic [63:0] mosi_pat,
                           input int chg_bit, input logic [9:0] chg_x);
    logic b;
    rx = '0;
    busy_mid = 1'b0;
    @(negedge clk);
    spi_if.SS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_val = chg_x;
      sclk_cycle(mosi_pat[63-i], b);
      rx = {rx[62:0], b};
      if (i == nbits / 2) busy_mid = busy;
    end
    repeat (8) @(negedge clk);
    spi_if.SS   = 1'b1;
    spi_if.MOSI = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    spi_if.SS = 1'b1;
    spi_if.SCLK = 1'b0;
    spi_if.MOSI = 1'b0;
    x_val = '0;
    y_val = '0;
    btn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (spi_if.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", spi_if.MISO); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
  endtask

  task automatic test_basic_frame();
    logic [39:0] exp;
    int f0;
    exp = 40'hA5023C0102;
    x_val = 10'h2A5; y_val = 10'h13C; btn = 2'b10;
    f0 = fd_cnt;
    run_frame(40, 64'h0, -1, 10'h0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx[39-8*k -: 8] !== exp[39-8*k -: 8]) begin
        errors++;
        $display("FAIL basic_byte%0d got %h exp %h", k, rx[39-8*k -: 8], exp[39-8*k -: 8]);
      end
    end
    checks++;
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL basic_frame_done got %0d exp 1", fd_cnt - f0); end
    checks++;
    if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy_mid got %b exp 1", busy_mid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_snapshot();
    x_val = 10'h000; y_val = 10'h000; btn = 2'b00;
    run_frame(40, 64'h0, 8, 10'h3FF);
    checks++;
    if (rx[39:32] !== 8'h00) begin errors++; $display("FAIL snap_byte0 got %h exp 00", rx[39:32]); end
    checks++;
    if (rx[31:24] !== 8'h00) begin errors++; $display("FAIL snap_byte1 got %h exp 00", rx[31:24]); end
    run_frame(40, 64'h0, -1, 10'h0);
    checks++;
    if (rx[39:32] !== 8'hFF) begin errors++; $display("FAIL snap_next_byte0 got %h exp ff", rx[39:32]); end
    checks++;
    if (rx[31:24] !== 8'h03) begin errors++; $display("FAIL snap_next_byte1 got %h exp 03", rx[31:24]); end
  endtask

  task automatic test_overclock();
    int f0;
    x_val = 10'h2A5; y_val = 10'h13C; btn = 2'b10;
    f0 = fd_cnt;
    run_frame(48, 64'h0, -1, 10'h0);
    checks++;
    if (rx[47:8] !== 40'hA5023C0102) begin errors++; $display("FAIL over_packet got %h exp a5023c0102", rx[47:8]); end
    checks++;
    if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL over_extra_bits got %h exp 00", rx[7:0]); end
    checks++;
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL over_frame_done got %0d exp 1", fd_cnt - f0); end
  endtask

  task automatic test_abort();
    int f0;
    x_val = 10'h2A5; y_val = 10'h13C; btn = 2'b10;
    f0 = fd_cnt;
    run_frame(13, 64'h0, -1, 10'h0);
    checks++;
    if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL abort_frame_done got %0d exp 0", fd_cnt - f0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    x_val = 10'h155; y_val = 10'h2AA; btn = 2'b01;
    f0 = fd_cnt;
    run_frame(40, 64'h0, -1, 10'h0);
    checks++;
    if (rx[39:0] !== 40'h5501AA0201) begin errors++; $display("FAIL abort_next_packet got %h exp 5501aa0201", rx[39:0]); end
    checks++;
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL abort_next_frame_done got %0d exp 1", fd_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    logic b;
    int   bad;
    int   f0;
    x_val = 10'h2A5; y_val = 10'h13C; btn = 2'b10;
    f0 = fd_cnt;
    bad = 0;
    @(negedge clk);
    spi_if.SS = 1'b0;
    for (int i = 0; i < 20; i++) sclk_cycle(1'b0, b);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (spi_if.MISO !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b exp 0", spi_if.MISO); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sclk_cycle(1'b0, b);
      if (b !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rstmid_ignored_edges got %0d active bits exp 0", bad); end
    repeat (8) @(negedge clk);
    spi_if.SS = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL rstmid_frame_done got %0d exp 0", fd_cnt - f0); end
    run_frame(40, 64'h0, -1, 10'h0);
    checks++;
    if (rx[39:0] !== 40'hA5023C0102) begin errors++; $display("FAIL rstmid_next_packet got %h exp a5023c0102", rx[39:0]); end
  endtask

`ifdef JSTK2_LED_CMD_EN
  task automatic test_led_cmd();
    int l0;
    x_val = 10'h2A5; y_val = 10'h13C; btn = 2'b10;
    l0 = lv_cnt;
    run_frame(40, {40'h8411223300, 24'h0}, -1, 10'h0);
    checks++;
    if (led_r !== 8'h11) begin errors++; $display("FAIL led_r got %h exp 11", led_r); end
    checks++;
    if (led_g !== 8'h22) begin errors++; $display("FAIL led_g got %h exp 22", led_g); end
    checks++;
    if (led_b !== 8'h33) begin errors++; $display("FAIL led_b got %h exp 33", led_b); end
    checks++;
    if (lv_cnt - l0 !== 1) begin errors++; $display("FAIL led_valid_pulses got %0d exp 1", lv_cnt - l0); end
    checks++;
    if (rx[39:0] !== 40'hA5023C0102) begin errors++; $display("FAIL led_miso_packet got %h exp a5023c0102", rx[39:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_snapshot();
    test_overclock();
    test_abort();
    test_reset_mid_frame();
`ifdef JSTK2_LED_CMD_EN
    test_led_cmd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
